// File: rtl/fsb8_pkg.sv
// Shared types and constants for the FSB8 SRAM target.
package fsb8_pkg;

    localparam int unsigned FSB_DATA_W = 8;
    localparam int unsigned FSB_ADDR_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER
    } state_t;

    // Bits above the memory window, with anything beyond the bus width cleared.
    function automatic logic [FSB_ADDR_W-1:0] base_field(
        input logic [FSB_ADDR_W-1:0] addr,
        input int unsigned           addr_w,
        input int unsigned           depth_log2
    );
        logic [FSB_ADDR_W-1:0] f;
        f = addr;
        for (int unsigned i = 0; i < FSB_ADDR_W; i++) begin
            if (i >= addr_w) f[i] = 1'b0;
        end
        return f >> depth_log2;
    endfunction

endpackage

// File: rtl/fsb8_spram.sv
// Single-port synchronous RAM with registered read data.
module fsb8_spram
  import fsb8_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [FSB_DATA_W-1:0] wdata,
  output logic [FSB_DATA_W-1:0] rdata
);

  logic [FSB_DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Output register reset maps onto the block RAM's output-latch reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (rst) rdata <= '0;
    else     rdata <= mem[addr];
  end

endmodule

// File: rtl/fsb8_sram_target.sv
// FSB8 bus target: address decode, wait states, block transfers and a
// mailbox interrupt in front of an on-chip SRAM.
module fsb8_sram_target
    import fsb8_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter int unsigned       DEPTH_LOG2  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned       WAIT_STATES = 2,
    parameter                    INIT_FILE   = ""
) (
    input  logic       sysclk,
    input  logic       sysrst,
    input  logic       ale_n,
    input  logic       cs_n,
    input  logic       cmd_n,
    input  logic       typ,
    input  logic       wr_n,
    input  logic [7:0] ad_i,
    input  logic [7:0] aah_i,
    output logic [7:0] ad_o,
    output logic       ad_oe,
    output logic       rdy_n,
    output logic       irq_n
);

    localparam int unsigned           WCNT_W = 4;
    localparam logic [DEPTH_LOG2-1:0] MBOX   = '1;

    state_t                  state;
    logic [15:0]             a_hi;
    logic [FSB_ADDR_W-1:0]   addr;
    logic                    hit;
    logic                    cs_prev;
    logic                    cs_fall;
    logic                    first;
    logic                    typ_l;
    logic                    wr_l;
    logic [WCNT_W-1:0]       wcnt;
    logic [DEPTH_LOG2-1:0]   offset;
    logic [DEPTH_LOG2-1:0]   offset_next;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic                    beat;
    logic                    we;
    logic                    rd_beat;
    logic [FSB_DATA_W-1:0]   rdata;

    assign addr    = {a_hi, aah_i};
    assign hit     = base_field(addr, ADDR_W, DEPTH_LOG2)
                     == base_field(FSB_ADDR_W'(BASE_ADDR), ADDR_W, DEPTH_LOG2);
    assign cs_fall = !cs_n && cs_prev;

    // A single transfer has exactly one beat, on its first XFER cycle.
    always_comb begin
        beat = 1'b0;
        if (state == XFER && !cs_n) beat = typ_l ? !cmd_n : first;
    end

    assign we      = beat && !wr_l && !sysrst;
    assign rd_beat = beat && wr_l;

    always_comb begin
        offset_next = offset;
        if (state == IDLE && cs_fall && hit)
            offset_next = addr[DEPTH_LOG2-1:0];
        else if (beat && typ_l)
            offset_next = offset + DEPTH_LOG2'(1);
    end

    // Reads look one offset ahead so ad_o changes on the same edge as the beat.
    assign ram_addr = we ? offset : offset_next;
    assign ad_o     = rdata;

    fsb8_spram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (sysclk),
        .rst   (sysrst),
        .we    (we),
        .addr  (ram_addr),
        .wdata (ad_i),
        .rdata (rdata)
    );

    always_ff @(posedge sysclk) begin
        cs_prev <= cs_n;
        if (sysrst) begin
            state  <= IDLE;
            ad_oe  <= 1'b0;
            rdy_n  <= 1'b1;
            irq_n  <= 1'b1;
            offset <= '0;
            a_hi   <= '0;
            wcnt   <= '0;
            first  <= 1'b0;
            typ_l  <= 1'b0;
            wr_l   <= 1'b1;
        end else begin
            offset <= offset_next;
            if (!ale_n && cs_n) a_hi <= {aah_i, ad_i};

            if (we && offset == MBOX)           irq_n <= 1'b0;
            else if (rd_beat && offset == MBOX) irq_n <= 1'b1;

            case (state)
                IDLE: begin
                    if (cs_fall && hit) begin
                        state <= WAIT;
                        wcnt  <= WCNT_W'(WAIT_STATES);
                        typ_l <= typ;
                        wr_l  <= wr_n;
                    end
                end
                WAIT: begin
                    if (cs_n) begin
                        state <= IDLE;
                    end else if (wcnt == '0) begin
                        state <= XFER;
                        rdy_n <= 1'b0;
                        ad_oe <= wr_l;
                        first <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                XFER: begin
                    first <= 1'b0;
                    if (cs_n) begin
                        state <= IDLE;
                        rdy_n <= 1'b1;
                        ad_oe <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
